gshare_branch_predictor: RTL

Parametrised gshare direction predictor for the fetch stage; successor to the single-entry Branch_Predictor.
- Decodes the fetched instruction and predicts taken/not-taken for branches the same cycle.
- Table of saturating counters indexed by PC XOR speculative global history.
- Tracks up to PENDING_DEPTH unresolved predictions in order, updates on resolution, and flushes/repairs history on a misprediction.

---
 rtl/gshare_branch_predictor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: PC^GHR indexed counters with an in-order pending queue.
// Define BP_PERF_COUNTERS_EN to add correct/mispredict resolve counters.
module gshare_branch_predictor #(
    parameter int         XLEN          = 32,
    parameter int         IDX_WIDTH     = 6,
    parameter int         GHR_WIDTH     = 6,
    parameter int         CTR_WIDTH     = 2,
    parameter int         PENDING_DEPTH = 4,
    parameter logic [6:0] BRANCH_OPCODE = 7'b1100011
) (
    input  logic            i_saat,
    input  logic            i_reset,
    input  logic            i_buyruk_gecerli,
    input  logic [XLEN-1:0] i_buyruk_sayaci,
    input  logic [XLEN-1:0] i_buyruk,
    output logic            o_dallanma,
    output logic            o_buyruk_ongoru,
    output logic            o_hazir,
    input  logic            i_sonuc_gecerli,
    input  logic            i_buyruk_atladi,
    output logic            o_ongoru_yanlis
`ifdef BP_PERF_COUNTERS_EN
    ,
    output logic [31:0]     o_dogru_sayisi,
    output logic [31:0]     o_yanlis_sayisi
`endif
);

    localparam int ENTRIES = 1 << IDX_WIDTH;
    localparam int PW      = $clog2(PENDING_DEPTH);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [PW:0]          DEPTH    = (PW+1)'(PENDING_DEPTH);
    localparam logic [PW:0]          LAST     = (PW+1)'(PENDING_DEPTH - 1);

    logic [CTR_WIDTH-1:0] ctr [ENTRIES];
    logic [GHR_WIDTH-1:0] ghr;

    logic [IDX_WIDTH-1:0] fifo_idx  [PENDING_DEPTH];
    logic                 fifo_pred [PENDING_DEPTH];
    logic [GHR_WIDTH-1:0] fifo_ghr  [PENDING_DEPTH];

    logic [PW:0] rd_ptr;
    logic [PW:0] wr_ptr;
    logic [PW:0] count;

    logic [IDX_WIDTH-1:0] ghr_ext;
    logic [IDX_WIDTH-1:0] idx;
    logic                 pred;
    logic [PW-1:0]        head;
    logic                 pop;
    logic                 miss;
    logic                 push;
    logic [CTR_WIDTH-1:0] head_ctr;
    logic [CTR_WIDTH-1:0] new_ctr;

    function automatic logic [GHR_WIDTH-1:0] shift_in(
        input logic [GHR_WIDTH-1:0] h,
        input logic                 b
    );
        logic [GHR_WIDTH:0] t;
        t = {h, b};
        return t[GHR_WIDTH-1:0];
    endfunction

    function automatic logic [PW:0] ptr_next(input logic [PW:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_WIDTH-1:0] = ghr;
    end

    assign idx  = i_buyruk_sayaci[IDX_WIDTH+1:2] ^ ghr_ext;
    assign pred = ctr[idx][CTR_WIDTH-1];

    assign o_dallanma      = i_buyruk_gecerli && (i_buyruk[6:0] == BRANCH_OPCODE);
    assign o_buyruk_ongoru = o_dallanma && pred;
    assign o_hazir         = count < DEPTH;

    assign head = rd_ptr[PW-1:0];
    assign pop  = i_sonuc_gecerli && (count != '0);
    assign miss = pop && (i_buyruk_atladi != fifo_pred[head]);
    // A mispredict squashes anything fetched down the wrong path, including this cycle's branch.
    assign push = o_dallanma && o_hazir && !miss;

    assign head_ctr = ctr[fifo_idx[head]];

    always_comb begin
        new_ctr = head_ctr;
        if (i_buyruk_atladi) begin
            if (head_ctr != CTR_MAX) new_ctr = head_ctr + 1'b1;
        end else begin
            if (head_ctr != '0) new_ctr = head_ctr - 1'b1;
        end
    end

    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
            ghr             <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            o_ongoru_yanlis <= 1'b0;
        end else begin
            o_ongoru_yanlis <= miss;
            if (pop) ctr[fifo_idx[head]] <= new_ctr;
            if (miss) begin
                ghr    <= shift_in(fifo_ghr[head], i_buyruk_atladi);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    ghr    <= shift_in(ghr, pred);
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_next(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge i_saat) begin
        if (push) begin
            fifo_idx[wr_ptr[PW-1:0]]  <= idx;
            fifo_pred[wr_ptr[PW-1:0]] <= pred;
            fifo_ghr[wr_ptr[PW-1:0]]  <= ghr;
        end
    end

`ifdef BP_PERF_COUNTERS_EN
    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            o_dogru_sayisi  <= '0;
            o_yanlis_sayisi <= '0;
        end else if (pop) begin
            if (miss) o_yanlis_sayisi <= o_yanlis_sayisi + 1'b1;
            else      o_dogru_sayisi  <= o_dogru_sayisi + 1'b1;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{i_buyruk[XLEN-1:7],
                           i_buyruk_sayaci[XLEN-1:IDX_WIDTH+2],
                           i_buyruk_sayaci[1:0],
                           rd_ptr[PW], wr_ptr[PW]};

endmodule
